// File: rtl/multipler_pkg.sv
// Shared types and defaults for the multiplier and the arbiter that fronts it.
package multipler_pkg;

  localparam int unsigned DATA_LENGTH = 8;
  localparam int unsigned ARB_NUM_REQ = 4;
  localparam int unsigned ARB_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic                       err;
    logic [2*DATA_LENGTH-1:0]   data;
  } arb_resp_t;

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set bit at or above ptr, with wrap-around.
module rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin : pick
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one multiplier among NUM_REQ clients, with a WAIT watchdog.
module mult_arbiter
  import multipler_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = ARB_NUM_REQ,
  parameter  int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT,
  localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_b_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [ID_W-1:0]                resp_id_o,
  output logic [2*DATA_LENGTH-1:0]       resp_data_o,
  output logic                           resp_err_o,
  output logic                           mul_start_o,
  input  logic                           mul_busy_i,
  input  logic                           mul_finish_i,
  output logic [DATA_LENGTH-1:0]         mul_a_o,
  output logic [DATA_LENGTH-1:0]         mul_b_o,
  input  logic [2*DATA_LENGTH-1:0]       mul_r_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]       wd_q, wd_d;
  logic [ID_W-1:0]        id_d;
  logic [DATA_LENGTH-1:0] a_d, b_d;
  arb_resp_t              resp_q, resp_d;
  logic                   start_d;
  logic                   valid_d;

  logic [NUM_REQ-1:0]     pick_req;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic                   hs;

  // A busy multiplier blocks all grants.
  assign pick_req = mul_busy_i ? '0 : req_valid_i;

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req       (pick_req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready_o = (state_q == IDLE) ? grant : '0;
  assign hs          = grant_any && (state_q == IDLE);
  assign resp_data_o = resp_q.data;
  assign resp_err_o  = resp_q.err;

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    id_d    = resp_id_o;
    a_d     = mul_a_o;
    b_d     = mul_b_o;
    resp_d  = resp_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              a_d = req_a_i[i*DATA_LENGTH +: DATA_LENGTH];
              b_d = req_b_i[i*DATA_LENGTH +: DATA_LENGTH];
            end
          end
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_finish_i) begin
          resp_d.err  = 1'b0;
          resp_d.data = mul_r_i;
          valid_d     = 1'b1;
          state_d     = RESP;
        end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_d.err  = 1'b1;
          resp_d.data = '0;
          valid_d     = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      RESP: begin
        valid_d = !resp_ready_i;
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      resp_id_o    <= '0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      resp_q       <= '0;
      mul_start_o  <= 1'b0;
      resp_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      resp_id_o    <= id_d;
      mul_a_o      <= a_d;
      mul_b_o      <= b_d;
      resp_q       <= resp_d;
      mul_start_o  <= start_d;
      resp_valid_o <= valid_d;
    end
  end

endmodule
